// File: rtl/pipe_mem_io.sv
// MEM-stage responder: word data RAM plus a small memory-mapped I/O page
// (LEDs, hex digits, synchronized switches/keys, cycle counter, key-press flags).
module pipe_mem_io #(
  parameter int RAM_AW = 5,
  parameter int SW_W   = 10,
  parameter int KEY_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       maddr,
  input  logic [31:0]       mwdata,
  input  logic              mwmem,
  input  logic              mm2reg,
  output logic [31:0]       mdout,
  input  logic [SW_W-1:0]   sw_in,
  input  logic [KEY_W-1:0]  key_in,
  output logic [SW_W-1:0]   led_out,
  output logic [23:0]       hex_out
);
  localparam int DEPTH = 1 << RAM_AW;

  logic              io_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic [2:0]        io_off;
  logic              ram_we, io_we;

  assign io_sel  = maddr[RAM_AW+2];
  assign ram_idx = maddr[RAM_AW+1:2];
  assign io_off  = maddr[4:2];
  assign ram_we  = mwmem & ~io_sel;
  assign io_we   = mwmem & io_sel;

  logic unused_addr;
  assign unused_addr = ^{maddr[31:RAM_AW+3], maddr[1:0]};

  logic [31:0] ram_q [DEPTH];

  logic [SW_W-1:0]  led_q, led_d;
  logic [23:0]      hex_q, hex_d;
  logic [31:0]      cyc_q, cyc_d;
  logic [SW_W-1:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [KEY_W-1:0] key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic [KEY_W-1:0] key_prev_q, key_prev_d, key_flag_q, key_flag_d;
  logic [KEY_W-1:0] key_sync, key_rise, key_clr;

  // Keys are active-low at the pins; key_sync is 1 while pressed.
  assign key_sync = ~key_s2_q;
  assign key_rise = key_sync & ~key_prev_q;

  always_comb begin
    led_d      = led_q;
    hex_d      = hex_q;
    cyc_d      = cyc_q + 32'd1;
    sw_s1_d    = sw_in;
    sw_s2_d    = sw_s1_q;
    key_s1_d   = key_in;
    key_s2_d   = key_s1_q;
    key_prev_d = key_sync;
    key_clr    = '0;
    if (io_we) begin
      case (io_off)
        3'd0:    led_d   = mwdata[SW_W-1:0];
        3'd1:    hex_d   = mwdata[23:0];
        3'd4:    cyc_d   = mwdata;
        3'd5:    key_clr = mwdata[KEY_W-1:0];
        default: ;
      endcase
    end
    // A press landing in the same cycle as a W1C clear survives.
    key_flag_d = (key_flag_q & ~key_clr) | key_rise;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      led_q      <= '0;
      hex_q      <= '0;
      cyc_q      <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      key_s1_q   <= '1;
      key_s2_q   <= '1;
      key_prev_q <= '0;
      key_flag_q <= '0;
    end else begin
      led_q      <= led_d;
      hex_q      <= hex_d;
      cyc_q      <= cyc_d;
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      key_s1_q   <= key_s1_d;
      key_s2_q   <= key_s2_d;
      key_prev_q <= key_prev_d;
      key_flag_q <= key_flag_d;
    end
  end

  // Data RAM keeps its contents across reset.
  always_ff @(posedge clock) begin
    if (ram_we) ram_q[ram_idx] <= mwdata;
  end

  logic [31:0] io_rd;
  always_comb begin
    io_rd = '0;
    case (io_off)
      3'd0:    io_rd = 32'(led_q);
      3'd1:    io_rd = 32'(hex_q);
      3'd2:    io_rd = 32'(sw_s2_q);
      3'd3:    io_rd = 32'(key_sync);
      3'd4:    io_rd = cyc_q;
      3'd5:    io_rd = 32'(key_flag_q);
      default: io_rd = '0;
    endcase
    mdout = '0;
    if (mm2reg) mdout = io_sel ? io_rd : ram_q[ram_idx];
  end

  assign led_out = led_q;
  assign hex_out = hex_q;
endmodule
